fc_output_collector: RTL
========================

// Module: fc_output_collector
// PURPOSE
//  Parametrised collector for fully-connected layer results (FC1 = 84, FC2 = 10, ...).
//  Shifts in one neuron result per accepted beat and presents all NUM_OUTPUTS results as one flat vector.
//  Uses a valid/ready handshake on input and valid/ack on output, with a fill counter and flush.
//  Sits between the FC MAC engine and the next FC layer or the classifier stage.
// PARAMETERS
//  DATA_WIDTH   32  width of one result word (IEEE-754 single)
//  NUM_OUTPUTS  84  number of neuron results per vector (>=2)
//  CNT_W        $clog2(NUM_OUTPUTS+1)  fill counter width (derived, do not override)
// PORTS
//  clk        in   1                       rising-edge clock
//  rst_n      in   1                       synchronous reset, active low
//  flush      in   1                       synchronous clear of count/valid (data regs untouched)
//  in_valid   in   1                       in_data holds a result
//  in_ready   out  1                       collector can accept (= !out_valid)
//  in_data    in   DATA_WIDTH              result word; first word accepted = neuron 1
//  out_valid  out  1                       full vector available
//  out_ack    in   1                       consumer has taken the vector
//  out_data   out  NUM_OUTPUTS*DATA_WIDTH  [k*DATA_WIDTH +: DATA_WIDTH] = neuron k+1 (oldest at k=0)
//  count      out  CNT_W                   results held, 0..NUM_OUTPUTS
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
//  Reset (rst_n=0 at posedge): all storage = 0, count = 0, out_valid = 0; in_ready = 1 on the following cycle.
//  Accept: in_valid & in_ready at posedge -> shift chain one place, new word enters the newest slot, count += 1.
//  Output mapping: after NUM_OUTPUTS accepts, word accepted n-th (1-based) appears at out_data slot n-1.
//  Full: an accept that brings count to NUM_OUTPUTS sets out_valid at that same edge (latency 1 cycle).
//    in_ready = !out_valid (combinational); no overwrite while full.
//  Drain: out_ack & out_valid at posedge -> count = 0, out_valid = 0; out_data holds its value until the next accept.
//    out_ack while !out_valid is ignored.
//  No bypass: in_valid in the cycle of the ack is not accepted (in_ready is low). The accept happens one cycle later.
//  Flush: at posedge sets count = 0, out_valid = 0.
//    Takes priority over accept and ack in the same cycle; rst_n has priority over flush.
//  Partial vector: out_valid stays 0 for count < NUM_OUTPUTS; there is no timeout.
//  Reset mid-fill: the in-progress vector is discarded and the next accepted word is neuron 1.
//  count never exceeds NUM_OUTPUTS; there is no wrap-around.
// CONFIGURATION
//  FC_COLLECT_RELU_EN defined: stored word = in_data[DATA_WIDTH-1] ? 0 : in_data.
//    ReLU on the sign bit; -0.0 is stored as +0.0.
//  FC_COLLECT_RELU_EN undefined: in_data is stored unchanged, negatives included.
//  Handshake, timing and latency are identical in both builds.
// STRUCTURE
//  lenet_pkg holds the shared constants:
//    LENET_DATA_WIDTH = 32, FC1_OUTPUTS = 84, FC2_OUTPUTS = 10, FP32_SIGN_BIT = 31.
//  Flat-slice helper function slot(k) also lives in lenet_pkg.
//  One sub-module: fp32_relu (combinational, DATA_WIDTH generic), instantiated only under FC_COLLECT_RELU_EN.
//  Shift chain and counter are implemented inline in a generate loop.
// TESTING
//  1 Reset, then 84 back-to-back accepts of data = k (k = 1..84) -> out_valid rises on the edge of the 84th accept.
//    Slot 0 = 1, slot 83 = 84; count = 84; in_ready = 0.
//  2 Full, in_valid held high for 5 cycles with no ack -> no shift, out_data unchanged; then ack -> count = 0.
//    Next word accepted exactly 1 cycle after ack.
//  3 in_valid toggled pseudo-randomly over 84 words -> same vector as scenario 1; count increments only on accepts.
//  4 Flush asserted at count = 40 together with in_valid -> count = 0, word not counted.
//    The next 84 words form a fresh vector.
//  5 rst_n low for 1 cycle at count = 50 -> count = 0, out_valid = 0, out_data = 0.
//    Refill with NUM_OUTPUTS = 10 build: out_valid after 10 accepts.
//  6 With FC_COLLECT_RELU_EN, inputs 0xBF800000 (-1.0) and 0x40000000 (2.0) -> stored 0x00000000 and 0x40000000.
//    Without the macro -> stored unchanged.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the flat-vector slice helper.
// Imported by the FC collector and its test bench.
package lenet_pkg;

  localparam int LENET_DATA_WIDTH = 32;
  localparam int FC1_OUTPUTS      = 84;
  localparam int FC2_OUTPUTS      = 10;
  localparam int FP32_SIGN_BIT    = 31;

  // LSB index of word k inside a flat vector of w-bit words
  function automatic int slot(input int k,
                              input int w = LENET_DATA_WIDTH);
    return k * w;
  endfunction

endpackage

// File: rtl/fp32_relu.sv
// Sign-bit ReLU: negative words (including -0.0) become +0.0.
// Ports: in_data (word in), out_data (rectified word out).
module fp32_relu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  always_comb begin
    out_data = in_data;
    if (in_data[DATA_WIDTH-1]) out_data = '0;
  end

endmodule

// File: rtl/fc_output_collector.sv
// Collects NUM_OUTPUTS FC results into one flat vector (oldest at slot 0).
// Ports: clk, rst_n (sync, active low), flush, in_valid/in_ready/in_data,
//   out_valid/out_ack/out_data, count. Macro FC_COLLECT_RELU_EN adds ReLU.
module fc_output_collector
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH  = LENET_DATA_WIDTH,
  parameter int NUM_OUTPUTS = FC1_OUTPUTS,
  parameter int CNT_W       = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  input  logic                              out_ack,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]                  count
);

  localparam int VW = NUM_OUTPUTS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] store_word;
  logic [VW-1:0]         data_q;
  logic [VW-1:0]         data_d;
  logic [VW-1:0]         shift_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic                  accept;
  logic                  drain;

`ifdef FC_COLLECT_RELU_EN
  fp32_relu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_relu (
    .in_data (in_data),
    .out_data(store_word)
  );
`else
  assign store_word = in_data;
`endif

  assign in_ready  = !out_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_ack && out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign count     = count_q;

  // Each slot takes its newer neighbour; the top slot takes the new word.
  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_chain
    if (k == NUM_OUTPUTS - 1) begin : g_top
      assign shift_d[slot(k, DATA_WIDTH) +: DATA_WIDTH] = store_word;
    end else begin : g_mid
      assign shift_d[slot(k, DATA_WIDTH) +: DATA_WIDTH] =
        data_q[slot(k + 1, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_comb begin
    data_d      = data_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (drain) begin
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      data_d  = shift_d;
      count_d = count_q + 1'b1;
      if (count_q == CNT_W'(NUM_OUTPUTS - 1)) out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
